// File: rtl/alu_pkg.sv
// Shared definitions for the ALU blocks: FSM state encoding and default datapath sizes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_SLICE_W = 8;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: Diff = A - B - Bin, Bout set when the bit underflows.
module full_subtractor_1bit (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor computing A - B - Bin one SLICE_W-bit slice per cycle, LSB first.
// Define SUB_STATUS_FLAGS_EN to add the Zero and Negative result flags.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SLICE_W = DEF_SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
`ifdef SUB_STATUS_FLAGS_EN
    output logic             Zero,
    output logic             Negative,
`endif
    output logic             Overflow
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0) begin : g_bad_cfg
        $error("serial_subtractor: WIDTH must be a multiple of SLICE_W");
    end

    sub_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
`ifdef SUB_STATUS_FLAGS_EN
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
`endif

    logic [SLICE_W-1:0] slice_a, slice_b, slice_diff;
    logic [SLICE_W:0]   bchain;
    int unsigned        base;

    always_comb begin
        base    = 32'(cnt_q) * SLICE_W;
        slice_a = a_q[base +: SLICE_W];
        slice_b = b_q[base +: SLICE_W];
    end

    // Ripple-borrow slice; the registered borrow carries between cycles.
    assign bchain[0] = borrow_q;
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fs
        full_subtractor_1bit u_fs (
            .A    (slice_a[i]),
            .B    (slice_b[i]),
            .Bin  (bchain[i]),
            .Diff (slice_diff[i]),
            .Bout (bchain[i+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
`ifdef SUB_STATUS_FLAGS_EN
        zero_d   = zero_q;
        neg_d    = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_d[base +: SLICE_W] = slice_diff;
                borrow_d                = bchain[SLICE_W];
                if (cnt_q == LAST_SLICE) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    bout_d  = bchain[SLICE_W];
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);
`ifdef SUB_STATUS_FLAGS_EN
                    zero_d  = (diff_d == '0);
                    neg_d   = diff_d[WIDTH-1];
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SUB_STATUS_FLAGS_EN
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
`ifdef SUB_STATUS_FLAGS_EN
            zero_q   <= zero_d;
            neg_q    <= neg_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Overflow  = ovf_q;
`ifdef SUB_STATUS_FLAGS_EN
    assign Zero      = zero_q;
    assign Negative  = neg_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: random and directed operands against an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned W  = 32;
    localparam int unsigned NS = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         Overflow;
`ifdef SUB_STATUS_FLAGS_EN
    logic         Zero;
    logic         Negative;
`endif

    serial_subtractor #(.WIDTH(W), .SLICE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
`ifdef SUB_STATUS_FLAGS_EN
        .Zero      (Zero),
        .Negative  (Negative),
`endif
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   stall_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain wide arithmetic, unsigned for borrow and signed for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t        e;
        logic [W:0]  u;
        longint      s;
        u = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        s = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        e.diff    = u[W-1:0];
        e.bout    = u[W];
        e.ovf     = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Consumer backpressure: hold out_ready low for stall_left cycles of out_valid.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: checks every cycle the result is presented, pops on handshake.
    initial begin
        bit first = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    if (first) check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(NS + 1));
                    first = 1'b0;
                    check("diff", 64'(Diff), 64'(exp_q[0].diff));
                    check("bout", 64'(Bout), 64'(exp_q[0].bout));
                    check("overflow", 64'(Overflow), 64'(exp_q[0].ovf));
                    check("in_ready_in_done", 64'(in_ready), 64'd0);
`ifdef SUB_STATUS_FLAGS_EN
                    check("zero", 64'(Zero), 64'(exp_q[0].diff == '0));
                    check("negative", 64'(Negative), 64'(exp_q[0].diff[W-1]));
`endif
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        first = 1'b1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input int stall, input bit noise);
        exp_t e;
        int   waited = 0;
        @(posedge clk);
        #1;
        A = a; B = b; Bin = bi; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(a, b, bi);
        e.acc_cyc = cyc;
        stall_left = stall;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (noise) begin
            for (int k = 0; k < NS; k++) begin
                in_valid = 1'($urandom_range(0, 1));
                A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_diff", 64'(Diff), 64'd0);
        check("reset_bout", 64'(Bout), 64'd0);
        check("reset_overflow", 64'(Overflow), 64'd0);

        issue(32'h0000_000A, 32'h0000_0003, 1'b0, 0, 1'b0);
        issue(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1, 1'b0);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        // Long backpressure with junk operands offered while busy.
        issue(32'h1234_5678, 32'h8765_4321, 1'b1, 10, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

        // Abort in the second BUSY cycle; no result may appear.
        @(posedge clk);
        #1;
        A = 32'hDEAD_BEEF; B = 32'h0000_0001; Bin = 1'b0; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("abort_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_diff", 64'(Diff), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        issue(32'd5, 32'd5, 1'b0, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            issue($urandom, $urandom, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_scoreboard", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001: Parameter WIDTH, default 32: operand and result width in bits.
REQ-002: Parameter SLICE_W, default 8: bits subtracted per cycle; WIDTH SHALL be an integer multiple of SLICE_W, with elaboration failing otherwise.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: in_valid  input  1  operands A, B and Bin are presented.
REQ-006: in_ready  output  1  block accepts operands this cycle.
REQ-007: A  input  WIDTH  minuend.
REQ-008: B  input  WIDTH  subtrahend.
REQ-009: Bin  input  1  borrow-in.
REQ-010: out_valid  output  1  result is held on the outputs.
REQ-011: out_ready  input  1  consumer takes the result.
REQ-012: Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH.
REQ-013: Bout  output  1  borrow out of the MSB; 1 when A < B + Bin (unsigned).
REQ-014: Overflow  output  1  two's-complement overflow.

Function
REQ-015: FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY on in_valid && in_ready.
- BUSY -> DONE after the final slice.
- DONE -> IDLE on out_ready.
REQ-016: in_ready SHALL be 1 only in IDLE.
REQ-017: out_valid SHALL be 1 only in DONE.
REQ-018: On accept, A, B and Bin SHALL be latched; later input changes have no effect.
REQ-019: BUSY SHALL last exactly WIDTH/SLICE_W cycles.
- Slice k (LSB first) uses bits [k*SLICE_W +: SLICE_W].
- The borrow into slice k is a registered borrow; Bin feeds slice 0.
REQ-020: Latency from the accept edge to out_valid=1 SHALL be WIDTH/SLICE_W + 1 cycles. Default configuration: 5.
REQ-021: Overflow SHALL equal (A[WIDTH-1] ^ B[WIDTH-1]) & (Diff[WIDTH-1] ^ A[WIDTH-1]).
REQ-022: Diff, Bout and Overflow SHALL hold stable while out_valid=1 and out_ready=0 (backpressure of any length).
REQ-023: No back-to-back accept: the earliest new accept is the cycle after the DONE->IDLE transition.
REQ-024: in_valid while BUSY or DONE SHALL be ignored and SHALL NOT be latched.
REQ-025: Slice counter SHALL wrap to 0 on entering DONE.

Reset
REQ-026: rst=1 SHALL, at the next edge, force state IDLE and clear counter, borrow register, Diff, Bout and Overflow (and flags, if present) to 0.
REQ-027: During and after reset: in_ready=1 in the first cycle after rst deasserts; out_valid=0.
REQ-028: rst asserted mid-BUSY or in DONE SHALL abort the operation and emit no result.
REQ-029: rst SHALL take priority over any simultaneous in_valid or out_ready.

Configuration
REQ-030: Macro SUB_STATUS_FLAGS_EN, when defined, SHALL add these outputs, valid with out_valid:
- Zero (1 bit): Diff == 0.
- Negative (1 bit): Diff[WIDTH-1].
REQ-031: Without SUB_STATUS_FLAGS_EN, the Zero and Negative ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032: Shared package alu_pkg SHALL hold:
- FSM state enum sub_state_t (IDLE, BUSY, DONE).
- Defaults DEF_WIDTH=32 and DEF_SLICE_W=8.
REQ-033: Sub-module full_subtractor_1bit (A, B, Bin -> Diff, Bout) SHALL be instantiated SLICE_W times to form the ripple-borrow slice datapath.

Verification
REQ-034: Basic subtract: A=0x0000000A, B=0x00000003, Bin=0 -> Diff=0x00000007, Bout=0, Overflow=0; out_valid exactly 5 cycles after accept.
REQ-035: Borrow ripple across all slices: A=0x00000000, B=0x00000001, Bin=0 -> Diff=0xFFFFFFFF, Bout=1, Overflow=0 (Negative=1 and Zero=0 when flags are enabled).
REQ-036: Signed overflow: A=0x80000000, B=0x00000001 -> Diff=0x7FFFFFFF, Overflow=1, Bout=0. Also A=0x7FFFFFFF, B=0xFFFFFFFF -> Diff=0x80000000, Overflow=1, Bout=1.
REQ-037: Backpressure and ignored input:
- Hold out_ready=0 for 10 cycles; outputs stay stable and in_ready=0 throughout.
- Toggle in_valid with new operands during BUSY; no effect on the result.
REQ-038: Reset mid-operation: assert rst in the 2nd BUSY cycle -> next cycle state IDLE, out_valid=0, Diff=0. A following A=5, B=5, Bin=0 -> Diff=0, Bout=0 (Zero=1 when flags are enabled).
